// File: rtl/i2s_master_rx.sv
// I2S bus master and stereo receiver: generates SCK/WS, primes the mic with one
// discarded half-frame, deserialises left/right samples and hands frames downstream.
module i2s_master_rx #(
    parameter int WIDTH      = 24,
    parameter int SLOTS      = 32,
    parameter int CLK_DIV    = 4,
    parameter int FIRST_SLOT = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    output logic             sck_o,
    output logic             ws_o,
    input  logic             sd_i,
    output logic [WIDTH-1:0] left_o,
    output logic [WIDTH-1:0] right_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o,
    input  logic             clr_ovf_i,
    output logic [15:0]      frame_cnt_o
);

    localparam int DIV_W  = 8;
    localparam int SLOT_W = $clog2(SLOTS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic               sck_q, sck_d;
    logic               ws_q, ws_d;
    logic [WIDTH-1:0]   left_sr_q, left_sr_d;
    logic [WIDTH-1:0]   right_sr_q, right_sr_d;
    logic               load_pend_q, load_pend_d;
    logic [WIDTH-1:0]   left_q, left_d;
    logic [WIDTH-1:0]   right_q, right_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic div_tick;
    logic rise_evt;
    logic fall_evt;
    logic slot_wrap;
    logic in_window;
    logic last_bit;
    logic transfer;

    always_comb begin
        div_tick  = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(CLK_DIV - 1));
        rise_evt  = div_tick && !sck_q;
        fall_evt  = div_tick && sck_q;
        slot_wrap = fall_evt && (slot_cnt_q == SLOT_W'(SLOTS - 1));
        in_window = (slot_cnt_q >= SLOT_W'(FIRST_SLOT)) &&
                    (slot_cnt_q <  SLOT_W'(FIRST_SLOT + WIDTH));
        last_bit  = slot_cnt_q == SLOT_W'(FIRST_SLOT + WIDTH - 1);
        transfer  = valid_q && ready_i;
    end

    // Bit clock, slot sequencing and channel capture
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        sck_d       = sck_q;
        ws_d        = ws_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        load_pend_d = 1'b0;

        if (state_q != ST_IDLE) begin
            div_cnt_d = div_tick ? '0 : div_cnt_q + DIV_W'(1);
            if (div_tick) begin
                sck_d = ~sck_q;
            end
            if (fall_evt) begin
                slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                div_cnt_d  = '0;
                slot_cnt_d = '0;
                sck_d      = 1'b0;
                ws_d       = 1'b0;
                if (enable_i) begin
                    // Preloading the last slot makes the first fall event a wrap,
                    // which is where WS goes high for the priming half-frame.
                    state_d    = ST_PRIME;
                    slot_cnt_d = SLOT_W'(SLOTS - 1);
                end
            end
            ST_PRIME: begin
                if (slot_wrap) begin
                    if (!ws_q) begin
                        ws_d = 1'b1;
                    end else if (enable_i) begin
                        ws_d    = 1'b0;
                        state_d = ST_LEFT;
                    end else begin
                        state_d    = ST_IDLE;
                        ws_d       = 1'b0;
                        sck_d      = 1'b0;
                        div_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end
                end
            end
            ST_LEFT: begin
                if (rise_evt && in_window) begin
                    left_sr_d = {left_sr_q[WIDTH-2:0], sd_i};
                end
                if (slot_wrap) begin
                    ws_d    = 1'b1;
                    state_d = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (rise_evt && in_window) begin
                    right_sr_d  = {right_sr_q[WIDTH-2:0], sd_i};
                    load_pend_d = last_bit;
                end
                if (slot_wrap) begin
                    if (enable_i) begin
                        ws_d    = 1'b0;
                        state_d = ST_LEFT;
                    end else begin
                        state_d    = ST_IDLE;
                        ws_d       = 1'b0;
                        sck_d      = 1'b0;
                        div_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake: valid_o/left_o/right_o hold until valid_o & ready_i; a frame
    // completing while the previous one is still held (and not taken) is dropped.
    always_comb begin
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;

        if (transfer) begin
            valid_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
        if (load_pend_q) begin
            if (!valid_q || ready_i) begin
                left_d  = left_sr_q;
                right_d = right_sr_q;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            sck_q       <= 1'b0;
            ws_q        <= 1'b0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            load_pend_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            sck_q       <= sck_d;
            ws_q        <= ws_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            load_pend_q <= load_pend_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sck_o       = sck_q;
    assign ws_o        = ws_q;
    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_i2s_master_rx.sv
// Directed bench for i2s_master_rx: an SD bus model replays fixed stereo words
// and every expectation below is hand-derived for CLK_DIV=4, SLOTS=32.
module tb_i2s_master_rx;

    localparam int WIDTH      = 24;
    localparam int SLOTS      = 32;
    localparam int CLK_DIV    = 4;
    localparam int FIRST_SLOT = 2;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic             sck_o;
    logic             ws_o;
    logic             sd_i;
    logic [WIDTH-1:0] left_o;
    logic [WIDTH-1:0] right_o;
    logic             valid_o;
    logic             ready_i;
    logic             overflow_o;
    logic             clr_ovf_i;
    logic [15:0]      frame_cnt_o;

    i2s_master_rx #(
        .WIDTH(WIDTH), .SLOTS(SLOTS), .CLK_DIV(CLK_DIV), .FIRST_SLOT(FIRST_SLOT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .sck_o(sck_o), .ws_o(ws_o),
        .sd_i(sd_i), .left_o(left_o), .right_o(right_o), .valid_o(valid_o),
        .ready_i(ready_i), .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i),
        .frame_cnt_o(frame_cnt_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SD bus model: new bit after each SCK fall, slot 0 at the WS change
    logic [WIDTH-1:0] mdl_left, mdl_right;
    int               mdl_slot = 0;
    logic             mdl_prev_sck = 1'b0;
    logic             mdl_prev_ws = 1'b0;

    function automatic logic model_bit(input logic ch, input int s);
        logic [WIDTH-1:0] w;
        w = ch ? mdl_right : mdl_left;
        if (s >= FIRST_SLOT && s < FIRST_SLOT + WIDTH) return w[WIDTH-1-(s-FIRST_SLOT)];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            mdl_prev_sck = 1'b0;
            mdl_prev_ws  = 1'b0;
            mdl_slot     = 0;
            sd_i         = 1'b0;
        end else begin
            if (mdl_prev_sck && !sck_o) begin
                if (ws_o != mdl_prev_ws) mdl_slot = 0;
                else mdl_slot++;
                mdl_prev_ws = ws_o;
                sd_i = model_bit(ws_o, mdl_slot);
            end
            mdl_prev_sck = sck_o;
        end
    end

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [47:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [47:0] e;
        e = exp_q.pop_front();
        check({tag, " left"}, left_o, e[47:24]);
        check({tag, " right"}, right_o, e[23:0]);
    endtask

    // driver tasks
    task automatic wait_valid(input string tag, input int budget, output int waited);
        waited = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (valid_o) begin
                waited = k;
                break;
            end
        end
        check({tag, " valid"}, valid_o, 1);
    endtask

    task automatic wait_slot(input string tag, input logic w, input int s, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ws_o == w && mdl_slot == s) break;
        end
        check({tag, " reached"}, (ws_o == w && mdl_slot == s), 1);
    endtask

    logic [95:0] all_out;
    assign all_out = {sck_o, ws_o, valid_o, overflow_o, left_o, right_o, frame_cnt_o};

    int first_sck, second_sck, ws_r1, ws_f1, ws_r2, valid_i, waited, act;
    logic p_sck, p_ws;

    initial begin
        rst_ni    = 1'b0;
        enable_i  = 1'b0;
        ready_i   = 1'b0;
        clr_ovf_i = 1'b0;
        mdl_left  = 24'hA5A5A5;
        mdl_right = 24'h5A5A5A;
        repeat (3) @(negedge clk);
        check("reset sck", sck_o, 0);
        check("reset ws", ws_o, 0);
        check("reset valid", valid_o, 0);
        check("reset overflow", overflow_o, 0);
        check("reset data/cnt", all_out, 0);

        rst_ni = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("idle outputs", all_out, 0);
        end

        // Clocking and first frame; observation i follows clock edge i after enable
        enable_i = 1'b1;
        exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        first_sck = -1; second_sck = -1; ws_r1 = -1; ws_f1 = -1; ws_r2 = -1; valid_i = -1;
        p_sck = 1'b0; p_ws = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (sck_o && !p_sck) begin
                if (first_sck < 0) first_sck = i;
                else if (second_sck < 0) second_sck = i;
            end
            if (ws_o && !p_ws) begin
                if (ws_r1 < 0) ws_r1 = i;
                else if (ws_r2 < 0) ws_r2 = i;
            end
            if (!ws_o && p_ws && ws_f1 < 0) ws_f1 = i;
            p_sck = sck_o;
            p_ws  = ws_o;
            if (valid_o) begin
                valid_i = i;
                break;
            end
        end
        check("first sck rise", first_sck, 4);
        check("sck period", second_sck - first_sck, 2 * CLK_DIV);
        check("ws rise at first fall", ws_r1, 8);
        check("ws fall (LEFT start)", ws_f1, 264);
        check("ws rise (RIGHT start)", ws_r2, 520);
        check("first valid cycle", valid_i, 725);
        check_frame("frame1");
        check("frame1 cnt", frame_cnt_o, 0);

        // Backpressure for 2.5 frames; later frames carry different words
        mdl_left  = 24'h123456;
        mdl_right = 24'hFEDCBA;
        repeat (1280) @(negedge clk);
        check("bp valid held", valid_o, 1);
        check("bp left held", left_o, 24'hA5A5A5);
        check("bp right held", right_o, 24'h5A5A5A);
        check("bp overflow", overflow_o, 1);
        check("bp cnt", frame_cnt_o, 0);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("one transfer valid", valid_o, 0);
        check("one transfer cnt", frame_cnt_o, 1);
        check("ovf sticky", overflow_o, 1);
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        check("ovf cleared", overflow_o, 0);

        ready_i = 1'b1;
        exp_q.push_back({24'h123456, 24'hFEDCBA});
        wait_valid("frame2", 600, waited);
        check("frame2 latency", waited, 253);
        check_frame("frame2");
        @(negedge clk);
        check("frame2 consumed", valid_o, 0);
        check("frame2 cnt", frame_cnt_o, 2);

        // Disable at LEFT slot 10: the frame still completes
        wait_slot("left slot 10", 1'b0, 10, 600);
        enable_i = 1'b0;
        exp_q.push_back({24'h123456, 24'hFEDCBA});
        wait_valid("disable frame", 600, waited);
        check_frame("disable frame");
        repeat (100) @(negedge clk);
        check("disabled sck", sck_o, 0);
        check("disabled ws", ws_o, 0);
        check("disabled cnt", frame_cnt_o, 3);
        act = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (valid_o || sck_o || ws_o) act++;
        end
        check("disabled quiet", act, 0);

        // Reset during RIGHT slot 15 of the second frame of a new run
        enable_i = 1'b1;
        exp_q.push_back({24'h123456, 24'hFEDCBA});
        wait_valid("rerun frame", 800, waited);
        check_frame("rerun frame");
        wait_slot("right slot 15", 1'b1, 15, 800);
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        @(negedge clk);
        check("mid reset outputs", all_out, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        act = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (valid_o || sck_o) act++;
        end
        check("post reset quiet", act, 0);

        enable_i = 1'b1;
        exp_q.push_back({24'h123456, 24'hFEDCBA});
        valid_i = -1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (valid_o) begin
                valid_i = i;
                break;
            end
        end
        check("reprime valid cycle", valid_i, 725);
        check_frame("reprime frame");
        @(negedge clk);
        check("reprime cnt", frame_cnt_o, 1);
        check("reprime no ovf", overflow_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
